// File: rtl/fir_coeff_sequencer.sv
// Double-banked FIR coefficient loader: latches coefficient pairs, streams them
// tap by tap into the inactive bank, and optionally swaps banks on a frame sync.
module fir_coeff_sequencer #(
    parameter int N_PAIRS = 8,
    parameter int COEF_W  = 16
) (
    input  logic                         user_clk,
    input  logic                         user_rst,
    input  logic [31:0]                  ctrl_reg,
    input  logic [32*N_PAIRS-1:0]        pairs_in,
    input  logic                         sync_in,
    input  logic                         coef_ready,
    output logic                         coef_we,
    output logic [$clog2(2*N_PAIRS)-1:0] coef_addr,
    output logic [COEF_W-1:0]            coef_data,
    output logic                         coef_bank,
    output logic                         active_bank,
    output logic [31:0]                  status_out
);
    localparam int N_TAPS = 2 * N_PAIRS;
    localparam int ADDR_W = $clog2(N_TAPS);
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N_TAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_WRITE,
        S_WAIT_SYNC,
        S_SWAP
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_idx;
    logic [32*N_PAIRS-1:0] r_shadow;
    logic                  r_swap_en;
    logic                  r_active;
    logic                  r_done;
    logic                  r_ctrl_d;
    logic                  r_armed;
    logic [7:0]            r_ign_cnt;
    logic [15:0]           r_load_cnt;

    logic w_req;
    logic w_busy;
    logic w_in_write;
    logic w_unused_ctrl;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Even taps come from the upper half of a pair, odd taps from the lower half.
    function automatic logic [COEF_W-1:0] tap_select(input logic [32*N_PAIRS-1:0] sh,
                                                    input logic [ADDR_W-1:0]     idx);
        logic [31:0] pair;
        pair = sh[32 * (int'(idx) / 2) +: 32];
        return idx[0] ? pair[COEF_W-1:0] : pair[31 -: COEF_W];
    endfunction

    // r_armed blocks a level that was already high when reset released.
    assign w_req         = ctrl_reg[0] & ~r_ctrl_d & r_armed;
    assign w_busy        = (r_state != S_IDLE);
    assign w_in_write    = (r_state == S_WRITE);
    assign w_unused_ctrl = ^ctrl_reg[31:2];

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_swap_en  <= 1'b0;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            r_ctrl_d   <= 1'b0;
            r_armed    <= 1'b0;
            r_ign_cnt  <= 8'd0;
            r_load_cnt <= 16'd0;
        end else begin
            r_ctrl_d <= ctrl_reg[0];
            if (!ctrl_reg[0]) begin
                r_armed <= 1'b1;
            end
            if (w_req && w_busy) begin
                r_ign_cnt <= sat_inc8(r_ign_cnt);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_state   <= S_LATCH;
                        r_done    <= 1'b0;
                        r_swap_en <= ctrl_reg[1];
                    end
                end
                S_LATCH: begin
                    r_idx   <= '0;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (coef_ready) begin
                        if (r_idx == LAST_TAP) begin
                            if (r_swap_en) begin
                                r_state <= S_WAIT_SYNC;
                            end else begin
                                r_state    <= S_IDLE;
                                r_done     <= 1'b1;
                                r_load_cnt <= r_load_cnt + 16'd1;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_WAIT_SYNC: begin
                    // Bank flip, done and count all land as SWAP is entered.
                    if (sync_in) begin
                        r_state    <= S_SWAP;
                        r_active   <= ~r_active;
                        r_done     <= 1'b1;
                        r_load_cnt <= r_load_cnt + 16'd1;
                    end
                end
                S_SWAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The shadow copy is pure data, so it is not reset; coef_data is gated instead.
    always_ff @(posedge user_clk) begin
        if (r_state == S_LATCH) begin
            r_shadow <= pairs_in;
        end
    end

    assign coef_we     = w_in_write & coef_ready;
    assign coef_addr   = r_idx;
    assign coef_data   = w_in_write ? tap_select(r_shadow, r_idx) : '0;
    assign coef_bank   = ~r_active;
    assign active_bank = r_active;
    assign status_out  = {r_ign_cnt, r_load_cnt, 4'b0000, r_active, r_done, w_busy, 1'b0};

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Self-checking bench for fir_coeff_sequencer with a tap-level reference model.
module tb_fir_coeff_sequencer;
    localparam int NP = 8;
    localparam int CW = 16;
    localparam int NT = 2 * NP;
    localparam int AW = 4;

    logic              user_clk = 1'b0;
    logic              user_rst;
    logic [31:0]       ctrl_reg;
    logic [32*NP-1:0]  pairs_in;
    logic              sync_in;
    logic              coef_ready;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [CW-1:0]     coef_data;
    logic              coef_bank;
    logic              active_bank;
    logic [31:0]       status_out;

    int checks = 0;
    int errors = 0;

    int m_loads = 0;
    int m_ign   = 0;
    bit m_bank  = 1'b0;
    logic [CW-1:0] exp_tap [NT];

    logic          cyc_we   [$];
    logic [AW-1:0] cyc_addr [$];
    logic [CW-1:0] cyc_data [$];
    logic          cyc_rdy  [$];

    always #5 user_clk = ~user_clk;

    fir_coeff_sequencer #(.N_PAIRS(NP), .COEF_W(CW)) dut (
        .user_clk   (user_clk),
        .user_rst   (user_rst),
        .ctrl_reg   (ctrl_reg),
        .pairs_in   (pairs_in),
        .sync_in    (sync_in),
        .coef_ready (coef_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_bank  (coef_bank),
        .active_bank(active_bank),
        .status_out (status_out)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge user_clk);
        #2;
    endtask

    function automatic logic [32*NP-1:0] rand_pairs();
        logic [32*NP-1:0] p;
        for (int k = 0; k < NP; k++) p[32*k +: 32] = $urandom;
        return p;
    endfunction

    // Tap i is half of pair i/2: the high half for even i, the low half for odd i.
    task automatic build_expect(input logic [32*NP-1:0] p);
        logic [31:0] pr;
        for (int i = 0; i < NT; i++) begin
            pr = p[32*(i/2) +: 32];
            exp_tap[i] = (i % 2 == 0) ? pr[31:16] : pr[15:0];
        end
    endtask

    function automatic logic [31:0] exp_status(input bit done, input bit busy);
        return {8'(m_ign), 16'(m_loads), 4'b0000, m_bank, done, busy, 1'b0};
    endfunction

    task automatic pulse_req(input bit swap);
        ctrl_reg = 32'h0;
        step();
        ctrl_reg = {30'b0, swap, 1'b1};
        step();
        ctrl_reg = 32'h0;
    endtask

    // mode 0: ready always, 1: ready 1,0,1,0..., 2: random, 3: ready low during request pulses.
    task automatic collect(input int mode, input int sync_at, input int n_req,
                           input int budget, output bit tout);
        int c  = 0;
        int nw = 0;
        cyc_we.delete(); cyc_addr.delete(); cyc_data.delete(); cyc_rdy.delete();
        tout = 1'b0;
        while (nw < NT) begin
            if (c >= budget) begin
                tout = 1'b1;
                break;
            end
            case (mode)
                0:       coef_ready = 1'b1;
                1:       coef_ready = (c % 2 == 0);
                2:       coef_ready = 1'($urandom_range(0, 1));
                default: coef_ready = (c >= 2 * n_req);
            endcase
            sync_in  = (c == sync_at);
            ctrl_reg = {31'b0, (c < 2 * n_req) && (c % 2 == 0)};
            pairs_in = rand_pairs();
            #1;
            cyc_we.push_back(coef_we);
            cyc_addr.push_back(coef_addr);
            cyc_data.push_back(coef_data);
            cyc_rdy.push_back(coef_ready);
            if (coef_we === 1'b1) nw++;
            c++;
            step();
        end
        sync_in  = 1'b0;
        ctrl_reg = 32'h0;
    endtask

    task automatic test_reset();
        user_rst   = 1'b1;
        ctrl_reg   = 32'h1;
        coef_ready = 1'b1;
        sync_in    = 1'b0;
        pairs_in   = rand_pairs();
        repeat (3) step();
        #1;
        checks++;
        if (coef_we !== 1'b0 || coef_addr !== '0 || coef_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs got we=%b addr=%0d data=%h expected 0 0 0", coef_we, coef_addr, coef_data);
        end
        checks++;
        if (active_bank !== 1'b0 || coef_bank !== 1'b1) begin
            errors++;
            $display("FAIL reset_banks got active=%b coef_bank=%b expected 0 1", active_bank, coef_bank);
        end
        checks++;
        if (status_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_status got %h expected 00000000", status_out);
        end
        user_rst = 1'b0;
        repeat (3) step();
        #1;
        checks++;
        if (status_out !== 32'h0 || coef_we !== 1'b0) begin
            errors++;
            $display("FAIL held_request got status=%h we=%b expected 00000000 0", status_out, coef_we);
        end
        ctrl_reg = 32'h0;
        step();
    endtask

    task automatic test_basic();
        logic [32*NP-1:0] p;
        bit tout;
        int wi;
        p = rand_pairs();
        p[31:0] = 32'h00060007;
        pairs_in = p;
        build_expect(p);
        coef_ready = 1'b1;
        pulse_req(1'b0);
        #1;
        checks++;
        if (coef_we !== 1'b0 || status_out[2:1] !== 2'b01) begin
            errors++;
            $display("FAIL basic_latch got we=%b done_busy=%b expected we=0 done_busy=01", coef_we, status_out[2:1]);
        end
        step();
        collect(0, -1, 0, 40, tout);
        wi = 0;
        foreach (cyc_we[j]) begin
            if (cyc_we[j] === 1'b1) begin
                checks++;
                if (cyc_addr[j] !== AW'(wi) || cyc_data[j] !== exp_tap[wi]) begin
                    errors++;
                    $display("FAIL basic_tap%0d got addr=%0d data=%h expected addr=%0d data=%h", wi, cyc_addr[j], cyc_data[j], wi, exp_tap[wi]);
                end
                wi++;
            end
        end
        checks++;
        if (wi != NT || cyc_we.size() != NT || tout) begin
            errors++;
            $display("FAIL basic_consecutive got writes=%0d cycles=%0d timeout=%0b expected %0d %0d 0", wi, cyc_we.size(), tout, NT, NT);
        end
        checks++;
        if (cyc_data.size() < 2 || cyc_data[0] !== 16'h0006 || cyc_data[1] !== 16'h0007) begin
            errors++;
            $display("FAIL basic_pair0 got size=%0d expected taps 0006 0007", cyc_data.size());
        end
        m_loads++;
        #1;
        checks++;
        if (status_out !== exp_status(1'b1, 1'b0) || active_bank !== 1'b0) begin
            errors++;
            $display("FAIL basic_status got %h bank=%b expected %h bank=0", status_out, active_bank, exp_status(1'b1, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [32*NP-1:0] p;
        bit tout;
        int wi;
        for (int n = 0; n < 4; n++) begin
            p = rand_pairs();
            pairs_in = p;
            build_expect(p);
            pulse_req(1'b0);
            step();
            collect(2, -1, 0, 300, tout);
            wi = 0;
            foreach (cyc_we[j]) begin
                if (cyc_we[j] === 1'b1) begin
                    checks++;
                    if (cyc_addr[j] !== AW'(wi) || cyc_data[j] !== exp_tap[wi]) begin
                        errors++;
                        $display("FAIL random%0d_tap%0d got addr=%0d data=%h expected addr=%0d data=%h", n, wi, cyc_addr[j], cyc_data[j], wi, exp_tap[wi]);
                    end
                    wi++;
                end
            end
            m_loads++;
            #1;
            checks++;
            if (wi != NT || tout || status_out !== exp_status(1'b1, 1'b0)) begin
                errors++;
                $display("FAIL random%0d_done got writes=%0d status=%h expected %0d %h", n, wi, status_out, NT, exp_status(1'b1, 1'b0));
            end
        end
    endtask

    task automatic test_stall();
        logic [32*NP-1:0] p;
        bit tout;
        int wi;
        p = rand_pairs();
        pairs_in = p;
        build_expect(p);
        pulse_req(1'b0);
        step();
        collect(1, -1, 0, 80, tout);
        wi = 0;
        foreach (cyc_we[j]) begin
            checks++;
            if (cyc_rdy[j] === 1'b1) begin
                if (cyc_we[j] !== 1'b1 || cyc_addr[j] !== AW'(wi) || cyc_data[j] !== exp_tap[wi]) begin
                    errors++;
                    $display("FAIL stall_write%0d got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h", wi, cyc_we[j], cyc_addr[j], cyc_data[j], wi, exp_tap[wi]);
                end
                wi++;
            end else if (cyc_we[j] !== 1'b0 || cyc_addr[j] !== AW'(wi) || cyc_data[j] !== exp_tap[wi]) begin
                errors++;
                $display("FAIL stall_hold%0d got we=%b addr=%0d data=%h expected we=0 addr=%0d data=%h", j, cyc_we[j], cyc_addr[j], cyc_data[j], wi, exp_tap[wi]);
            end
        end
        m_loads++;
        #1;
        checks++;
        if (wi != NT || tout || cyc_we.size() != 2 * NT - 1 || status_out !== exp_status(1'b1, 1'b0)) begin
            errors++;
            $display("FAIL stall_done got writes=%0d cycles=%0d status=%h expected %0d %0d %h", wi, cyc_we.size(), status_out, NT, 2 * NT - 1, exp_status(1'b1, 1'b0));
        end
    endtask

    task automatic test_swap();
        logic [32*NP-1:0] p;
        bit tout;
        int wi;
        p = rand_pairs();
        pairs_in = p;
        build_expect(p);
        pulse_req(1'b1);
        step();
        collect(0, 3, 0, 40, tout);
        wi = 0;
        foreach (cyc_we[j]) begin
            if (cyc_we[j] === 1'b1) begin
                if (cyc_data[j] === exp_tap[wi] && cyc_addr[j] === AW'(wi)) wi++;
            end
        end
        checks++;
        if (wi != NT || tout) begin
            errors++;
            $display("FAIL swap_writes got matching=%0d timeout=%0b expected %0d 0", wi, tout, NT);
        end
        coef_ready = 1'b1;
        #1;
        checks++;
        if (status_out !== exp_status(1'b0, 1'b1) || coef_we !== 1'b0 || active_bank !== m_bank) begin
            errors++;
            $display("FAIL swap_wait got status=%h we=%b bank=%b expected %h 0 %b", status_out, coef_we, active_bank, exp_status(1'b0, 1'b1), m_bank);
        end
        repeat (4) step();
        step();
        sync_in = 1'b1;
        #1;
        checks++;
        if (active_bank !== m_bank || status_out[1] !== 1'b1) begin
            errors++;
            $display("FAIL swap_before_sync got bank=%b busy=%b expected %b 1", active_bank, status_out[1], m_bank);
        end
        step();
        sync_in = 1'b0;
        m_bank  = ~m_bank;
        m_loads++;
        #1;
        checks++;
        if (active_bank !== m_bank || coef_bank !== ~m_bank || status_out !== exp_status(1'b1, 1'b1)) begin
            errors++;
            $display("FAIL swap_toggle got bank=%b coef_bank=%b status=%h expected %b %b %h", active_bank, coef_bank, status_out, m_bank, ~m_bank, exp_status(1'b1, 1'b1));
        end
        step();
        #1;
        checks++;
        if (status_out !== exp_status(1'b1, 1'b0)) begin
            errors++;
            $display("FAIL swap_idle got %h expected %h", status_out, exp_status(1'b1, 1'b0));
        end
    endtask

    task automatic test_ignored();
        logic [32*NP-1:0] p;
        bit tout;
        int wi;
        int nreq [2] = '{3, 300};
        for (int n = 0; n < 2; n++) begin
            p = rand_pairs();
            pairs_in = p;
            build_expect(p);
            pulse_req(1'b0);
            step();
            collect(3, -1, nreq[n], 2 * nreq[n] + 40, tout);
            wi = 0;
            foreach (cyc_we[j]) begin
                if (cyc_we[j] === 1'b1) begin
                    checks++;
                    if (cyc_addr[j] !== AW'(wi) || cyc_data[j] !== exp_tap[wi]) begin
                        errors++;
                        $display("FAIL ignored%0d_tap%0d got addr=%0d data=%h expected addr=%0d data=%h", n, wi, cyc_addr[j], cyc_data[j], wi, exp_tap[wi]);
                    end
                    wi++;
                end
            end
            m_ign = (m_ign + nreq[n] > 255) ? 255 : m_ign + nreq[n];
            m_loads++;
            #1;
            checks++;
            if (wi != NT || tout || status_out !== exp_status(1'b1, 1'b0)) begin
                errors++;
                $display("FAIL ignored%0d_count got writes=%0d status=%h expected %0d %h", n, wi, status_out, NT, exp_status(1'b1, 1'b0));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [32*NP-1:0] p;
        bit tout;
        int wi;
        p = rand_pairs();
        pairs_in = p;
        build_expect(p);
        pulse_req(1'b0);
        step();
        coef_ready = 1'b1;
        repeat (4) step();
        user_rst = 1'b1;
        #1;
        checks++;
        if (coef_we !== 1'b1 || coef_addr !== AW'(4)) begin
            errors++;
            $display("FAIL rst_fifth_write got we=%b addr=%0d expected 1 4", coef_we, coef_addr);
        end
        step();
        user_rst = 1'b0;
        m_loads = 0; m_ign = 0; m_bank = 1'b0;
        #1;
        checks++;
        if (coef_we !== 1'b0 || status_out !== 32'h0 || active_bank !== 1'b0 || coef_bank !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_write got we=%b status=%h bank=%b coef_bank=%b expected 0 00000000 0 1", coef_we, status_out, active_bank, coef_bank);
        end
        pulse_req(1'b1);
        step();
        collect(0, -1, 0, 40, tout);
        #1;
        checks++;
        if (tout || status_out !== exp_status(1'b0, 1'b1)) begin
            errors++;
            $display("FAIL rst_wait_entry got status=%h timeout=%0b expected %h 0", status_out, tout, exp_status(1'b0, 1'b1));
        end
        user_rst = 1'b1;
        step();
        user_rst = 1'b0;
        sync_in  = 1'b1;
        step();
        sync_in  = 1'b0;
        #1;
        checks++;
        if (status_out !== 32'h0 || active_bank !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wait got status=%h bank=%b expected 00000000 0", status_out, active_bank);
        end
        p = rand_pairs();
        pairs_in = p;
        build_expect(p);
        pulse_req(1'b0);
        step();
        collect(2, -1, 0, 300, tout);
        wi = 0;
        foreach (cyc_we[j]) begin
            if (cyc_we[j] === 1'b1) begin
                checks++;
                if (cyc_addr[j] !== AW'(wi) || cyc_data[j] !== exp_tap[wi]) begin
                    errors++;
                    $display("FAIL rst_reload_tap%0d got addr=%0d data=%h expected addr=%0d data=%h", wi, cyc_addr[j], cyc_data[j], wi, exp_tap[wi]);
                end
                wi++;
            end
        end
        m_loads++;
        #1;
        checks++;
        if (wi != NT || tout || status_out !== exp_status(1'b1, 1'b0)) begin
            errors++;
            $display("FAIL rst_reload_done got writes=%0d status=%h expected %0d %h", wi, status_out, NT, exp_status(1'b1, 1'b0));
        end
    endtask

    initial begin
        user_rst   = 1'b1;
        ctrl_reg   = 32'h0;
        pairs_in   = '0;
        sync_in    = 1'b0;
        coef_ready = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_stall();
        test_swap();
        test_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
